mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter sharing the single-port data RAM between the CPU and the screen refresh fetcher. The CPU is the priority requester; the screen fetcher reads the framebuffer window, and an anti-starvation counter guarantees it a slot. Sits between CPU/screen and Memory on the `clk` domain, and routes each 1-cycle-latency read return back to the requester that issued it.

## Interface

- `ADDR_W`, 15: RAM word-address width.
- `SCREEN_BASE`, 15'h4000: word address of framebuffer word 0.
- `SCR_AW`, 13: screen offset width (8K-word framebuffer).
- `MAX_WAIT`, 4: maximum number of consecutive denied screen-request cycles before the screen is forced to win; range 1..15.

- `clk` in 1: system clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `cpu_req` in 1: CPU access request, level-sensitive.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in ADDR_W: CPU word address.
- `cpu_wdata` in 16: CPU write data.
- `cpu_ack` out 1: CPU access issued this cycle.
- `cpu_rvalid` out 1: CPU read data valid.
- `cpu_rdata` out 16: CPU read data.
- `scr_req` in 1: screen read request, level-sensitive.
- `scr_addr` in SCR_AW: framebuffer word offset.
- `scr_ack` out 1: screen read issued this cycle.
- `scr_rvalid` out 1: screen read data valid.
- `scr_rdata` out 16: screen read data.
- `mem_en` out 1: RAM access enable.
- `mem_we` out 1: RAM write enable.
- `mem_addr` out ADDR_W: RAM address.
- `mem_wdata` out 16: RAM write data.
- `mem_rdata` in 16: RAM read data, valid the cycle after a read is issued.

## Operation

- **Request handshake**
  - A requester holds `req` and its address/data stable until it sees its `ack`.
  - `ack` is combinational and asserts in the cycle the access is driven onto `mem_*`.
  - The requester may drop `req` or present a new request in the cycle after `ack`.
- **Grant decision**, evaluated every cycle:
  - Only one requester active: that requester wins.
  - Both active: CPU wins unless `starve == MAX_WAIT`, in which case the screen wins.
  - Neither active: `mem_en` = 0.
- **Starvation counter** `starve` (4 bits):
  - Increments when `scr_req` is high and the screen is not granted.
  - Clears to 0 when the screen is granted or `scr_req` is low.
  - Saturates at `MAX_WAIT`.
- **Memory drive**
  - `mem_en` = 1 when any requester is granted.
  - `mem_we` = `cpu_we` only on a CPU grant; 0 otherwise.
  - `mem_addr` = `cpu_addr` on a CPU grant; `SCREEN_BASE + scr_addr` (modulo 2^ADDR_W) on a screen grant.
  - `mem_wdata` = `cpu_wdata`.
  - The screen never writes.
- **Return routing**
  - Tag register `rtag`, loaded every cycle with one of: {none, cpu, scr}.
  - A CPU write or an idle cycle loads "none".
- **Read data**
  - In the cycle after a CPU read issue: `cpu_rvalid` = 1, and `cpu_rdata` = `mem_rdata`, captured into a hold register.
  - Outside that cycle, `cpu_rdata` shows the hold register.
  - The screen side behaves identically.
  - Each rdata retains its last value until that requester's next read returns.
- **Back-to-back accesses**: one access per cycle, so sustained throughput is 1 access/clk. A read issued at N and any access issued at N+1 do not conflict.

## Timing

- **Reset values**
  - `rtag` = none, `starve` = 0, both hold registers = 0.
  - `cpu_rvalid` = `scr_rvalid` = 0; `cpu_rdata` = `scr_rdata` = 0.
  - While `reset` is high: `cpu_ack` = `scr_ack` = `mem_en` = `mem_we` = 0.
- **Read latency**: issue at cycle N (`ack` = 1), `rvalid` at N+1. Write completes at issue.
- **Reset mid-read**: if `reset` asserts in the cycle after an issue, that `rvalid` is suppressed and the return is discarded. After reset deasserts, arbitration resumes on the next edge.
- **Forced screen win**
  - The screen can wait at most `MAX_WAIT` consecutive denied cycles; it is granted on cycle `MAX_WAIT`+1 of continuous contention.
  - The CPU is then delayed exactly one cycle and wins the following cycle (`starve` resets to 0).
- **Simultaneous events**: same-cycle requests are resolved purely by the rule above. No request is latched internally, so a requester that drops `req` before `ack` is simply not served.

## Test plan

- **CPU write/read round trip**
  - Stimulus: CPU writes 16'hBEEF to 15'h0010 with `scr_req` = 0, then reads 15'h0010.
  - Required: `cpu_ack` on both issue cycles; `mem_we` = 1 only on the write; `cpu_rvalid` one cycle after the read ack with `cpu_rdata` = 16'hBEEF, held afterwards.
- **Screen address offset**
  - Stimulus: `scr_addr` = 13'h0005 alone.
  - Required: `mem_addr` = 15'h4005, `mem_we` = 0, `scr_ack` = 1; `scr_rvalid` next cycle carrying that word.
- **Starvation, `MAX_WAIT` = 4**
  - Stimulus: CPU and screen request continuously.
  - Required: CPU acked cycles 0-3, screen acked cycle 4, CPU cycle 5; pattern repeats with period 5.
- **Return routing under interleave**
  - Stimulus: CPU read at N, screen read at N+1.
  - Required: `cpu_rvalid` only at N+1, `scr_rvalid` only at N+2; each rdata matches its address; no cross-assignment.
- **Reset mid-operation**
  - Stimulus: CPU read acked at N, `reset` pulsed during N+1.
  - Required: `cpu_rvalid` = 0 at N+1; all outputs at reset values; `starve` = 0; the next request after release is served normally.
- **Address wrap**
  - Stimulus: `SCREEN_BASE` = 15'h7FFF, `scr_addr` = 13'h0002.
  - Required: `mem_addr` = 15'h0001.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// CPU / screen-fetcher / RAM bundle around the shared data RAM arbiter.
`timescale 1ns/1ps
interface mem_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int SCR_AW = 13
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [15:0]       cpu_wdata;
  logic              cpu_ack;
  logic              cpu_rvalid;
  logic [15:0]       cpu_rdata;

  logic              scr_req;
  logic [SCR_AW-1:0] scr_addr;
  logic              scr_ack;
  logic              scr_rvalid;
  logic [15:0]       scr_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;

  // Arbiter side.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, scr_req, scr_addr, mem_rdata,
    output cpu_ack, cpu_rvalid, cpu_rdata, scr_ack, scr_rvalid, scr_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  // Requesters plus RAM (the environment around the arbiter).
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, scr_req, scr_addr, mem_rdata,
    input  cpu_ack, cpu_rvalid, cpu_rdata, scr_ack, scr_rvalid, scr_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// CPU-priority arbiter for the single-port data RAM with a starvation-bounded
// screen fetch slot and 1-cycle read-return routing to the issuing requester.
`timescale 1ns/1ps

// Per-requester return lane: passes RAM data through on the return cycle and
// holds it until that requester's next read returns.
module mem_arb_ret (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_ret,
  input  logic [15:0] i_rdata,
  output logic        o_rvalid,
  output logic [15:0] o_rdata
);
  logic [15:0] r_hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      r_hold <= '0;
    else if (i_ret) r_hold <= i_rdata;
  end

  assign o_rvalid = i_ret;
  assign o_rdata  = i_ret ? i_rdata : r_hold;
endmodule

module mem_arbiter #(
  parameter int               ADDR_W      = 15,
  parameter logic [ADDR_W-1:0] SCREEN_BASE = 'h4000,
  parameter int               SCR_AW      = 13,
  parameter int               MAX_WAIT    = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);
  localparam int         NUM_REQ = 2;
  localparam logic [3:0] MAX_W   = 4'(MAX_WAIT);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_CPU  = 2'd1,
    TAG_SCR  = 2'd2
  } tag_e;

  logic [3:0]        r_starve;
  tag_e              r_rtag;
  tag_e              w_rtag_nxt;
  logic              w_starved;
  logic              w_cpu_win;
  logic              w_scr_win;
  logic [ADDR_W-1:0] w_scr_mem_addr;

  logic [NUM_REQ-1:0]       w_ret;
  logic [NUM_REQ-1:0]       w_rvalid;
  logic [NUM_REQ-1:0][15:0] w_rdata;

  // Grants are forced low during reset so nothing reaches the RAM.
  assign w_starved = (r_starve == MAX_W);
  assign w_scr_win = !reset && bus.scr_req && (!bus.cpu_req || w_starved);
  assign w_cpu_win = !reset && bus.cpu_req && !w_scr_win;

  assign w_scr_mem_addr = SCREEN_BASE + {{(ADDR_W-SCR_AW){1'b0}}, bus.scr_addr};

  assign bus.cpu_ack   = w_cpu_win;
  assign bus.scr_ack   = w_scr_win;
  assign bus.mem_en    = w_cpu_win | w_scr_win;
  assign bus.mem_we    = w_cpu_win & bus.cpu_we;
  assign bus.mem_addr  = w_scr_win ? w_scr_mem_addr : bus.cpu_addr;
  assign bus.mem_wdata = bus.cpu_wdata;

  always_comb begin
    w_rtag_nxt = TAG_NONE;
    if (w_scr_win)                     w_rtag_nxt = TAG_SCR;
    else if (w_cpu_win && !bus.cpu_we) w_rtag_nxt = TAG_CPU;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve <= '0;
      r_rtag   <= TAG_NONE;
    end else begin
      r_rtag <= w_rtag_nxt;
      if (!bus.scr_req || w_scr_win) r_starve <= '0;
      else if (!w_starved)           r_starve <= r_starve + 4'd1;
    end
  end

  // Lane 0 = CPU, lane 1 = screen.
  assign w_ret[0] = (r_rtag == TAG_CPU);
  assign w_ret[1] = (r_rtag == TAG_SCR);

  genvar g;
  generate
    for (g = 0; g < NUM_REQ; g++) begin : g_ret
      mem_arb_ret u_ret (
        .clk      (clk),
        .reset    (reset),
        .i_ret    (w_ret[g]),
        .i_rdata  (bus.mem_rdata),
        .o_rvalid (w_rvalid[g]),
        .o_rdata  (w_rdata[g])
      );
    end
  endgenerate

  assign bus.cpu_rvalid = w_rvalid[0];
  assign bus.cpu_rdata  = w_rdata[0];
  assign bus.scr_rvalid = w_rvalid[1];
  assign bus.scr_rdata  = w_rdata[1];
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized + directed bench for mem_arbiter against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int          AW   = 15;
  localparam int          SW   = 13;
  localparam int          MW   = 4;
  localparam logic [14:0] BASE = 15'h4000;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .SCR_AW(SW)) bus ();
  mem_arbiter_if #(.ADDR_W(AW), .SCR_AW(SW)) wbus ();

  mem_arbiter #(.ADDR_W(AW), .SCREEN_BASE(BASE), .SCR_AW(SW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  mem_arbiter #(.ADDR_W(AW), .SCREEN_BASE(15'h7FFF), .SCR_AW(SW), .MAX_WAIT(MW)) dut_w (
    .clk(clk), .reset(reset), .bus(wbus)
  );

  function automatic logic [15:0] seed_word(input logic [14:0] a);
    return {1'b1, a} ^ 16'h5A5A;
  endfunction

  // RAM behind the arbiter: 1-cycle read latency, refilled with seed data in reset.
  logic [15:0] ram [0:32767];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32768; i++) ram[i] <= seed_word(15'(i));
    end else if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= ram[bus.mem_addr];
    end
  end

  // Reference model state.
  logic [15:0] sram [0:32767];
  int          m_wait;
  bit          m_cpend, m_spend;
  logic [15:0] m_cdata, m_sdata;
  logic        obs_cack;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wait  = 0;
    m_cpend = 1'b0;
    m_spend = 1'b0;
    m_cdata = '0;
    m_sdata = '0;
    for (int i = 0; i < 32768; i++) sram[i] = seed_word(15'(i));
  endtask

  // One clock: drive at posedge+1, check mid-cycle, advance model, land on next posedge+1.
  task automatic cyc(input bit creq, input bit cwe, input logic [14:0] caddr,
                     input logic [15:0] cwd, input bit sreq, input logic [12:0] saddr);
    bit          sw, cw;
    logic [14:0] sa;
    bus.cpu_req   = creq;
    bus.cpu_we    = cwe;
    bus.cpu_addr  = caddr;
    bus.cpu_wdata = cwd;
    bus.scr_req   = sreq;
    bus.scr_addr  = saddr;
    #3;
    sw = sreq && (!creq || m_wait == MW);
    cw = creq && !sw;
    sa = BASE + {2'b00, saddr};
    obs_cack = bus.cpu_ack;
    chk("cpu_ack", 32'(bus.cpu_ack), 32'(cw));
    chk("scr_ack", 32'(bus.scr_ack), 32'(sw));
    chk("mem_en",  32'(bus.mem_en),  32'(cw || sw));
    chk("mem_we",  32'(bus.mem_we),  32'(cw && cwe));
    if (cw)        chk("mem_addr_cpu", 32'(bus.mem_addr), 32'(caddr));
    if (sw)        chk("mem_addr_scr", 32'(bus.mem_addr), 32'(sa));
    if (cw && cwe) chk("mem_wdata", 32'(bus.mem_wdata), 32'(cwd));
    chk("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(m_cpend));
    chk("scr_rvalid", 32'(bus.scr_rvalid), 32'(m_spend));
    chk("cpu_rdata",  32'(bus.cpu_rdata),  32'(m_cdata));
    chk("scr_rdata",  32'(bus.scr_rdata),  32'(m_sdata));
    m_cpend = cw && !cwe;
    if (cw && !cwe) m_cdata = sram[caddr];
    if (cw && cwe)  sram[caddr] = cwd;
    m_spend = sw;
    if (sw) m_sdata = sram[sa];
    if (sreq && !sw) m_wait = (m_wait < MW) ? m_wait + 1 : m_wait;
    else             m_wait = 0;
    @(posedge clk); #1;
  endtask

  // Reset asserted for one cycle from posedge+1 with requests pending.
  task automatic pulse_reset(input bit creq, input bit sreq);
    reset       = 1'b1;
    bus.cpu_req = creq;
    bus.cpu_we  = 1'b0;
    bus.scr_req = sreq;
    #3;
    chk("rst_cpu_ack",    32'(bus.cpu_ack),    32'd0);
    chk("rst_scr_ack",    32'(bus.scr_ack),    32'd0);
    chk("rst_mem_en",     32'(bus.mem_en),     32'd0);
    chk("rst_mem_we",     32'(bus.mem_we),     32'd0);
    chk("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    chk("rst_scr_rvalid", 32'(bus.scr_rvalid), 32'd0);
    chk("rst_cpu_rdata",  32'(bus.cpu_rdata),  32'd0);
    chk("rst_scr_rdata",  32'(bus.scr_rdata),  32'd0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    bit          creq, cwe, sreq;
    logic [14:0] caddr;
    logic [12:0] saddr;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.scr_req = 0; bus.scr_addr = '0;
    wbus.cpu_req = 0; wbus.cpu_we = 0; wbus.cpu_addr = '0; wbus.cpu_wdata = '0;
    wbus.scr_req = 1; wbus.scr_addr = 13'h0002; wbus.mem_rdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    pulse_reset(1'b1, 1'b1);

    // CPU write then read round trip.
    cyc(1, 1, 15'h0010, 16'hBEEF, 0, '0);
    chk("wrap_scr_ack",  32'(wbus.scr_ack),  32'd1);
    chk("wrap_mem_addr", 32'(wbus.mem_addr), 32'h0001);
    cyc(1, 0, 15'h0010, 16'h0000, 0, '0);
    chk("rt_rvalid", 32'(bus.cpu_rvalid), 32'd1);
    chk("rt_rdata",  32'(bus.cpu_rdata),  32'hBEEF);
    cyc(0, 0, '0, '0, 0, '0);
    cyc(0, 0, '0, '0, 0, '0);
    chk("rt_hold", 32'(bus.cpu_rdata), 32'hBEEF);

    // Screen offset.
    cyc(0, 0, '0, '0, 1, 13'h0005);
    chk("scr_rv",   32'(bus.scr_rvalid), 32'd1);
    chk("scr_data", 32'(bus.scr_rdata),  32'(seed_word(15'h4005)));
    cyc(0, 0, '0, '0, 0, '0);

    // Continuous contention: period-5 grant pattern.
    for (int k = 0; k < 15; k++) begin
      cyc(1, 0, 15'($urandom_range(0, 255)), '0, 1, 13'($urandom_range(0, 255)));
      chk("starve_period", 32'(obs_cack), 32'(k % 5 != 4));
    end
    cyc(0, 0, '0, '0, 0, '0);

    // Interleaved returns.
    cyc(1, 0, 15'h0123, '0, 0, '0);
    cyc(0, 0, '0, '0, 1, 13'h0042);
    chk("il_cpu_rv",   32'(bus.cpu_rvalid), 32'd0);
    chk("il_scr_rv",   32'(bus.scr_rvalid), 32'd1);
    chk("il_scr_data", 32'(bus.scr_rdata),  32'(seed_word(15'h4042)));
    chk("il_cpu_data", 32'(bus.cpu_rdata),  32'(seed_word(15'h0123)));
    cyc(0, 0, '0, '0, 0, '0);

    // Reset on the cycle after a CPU read issue, with starvation built up.
    cyc(1, 0, 15'h0300, '0, 1, 13'h0001);
    cyc(1, 0, 15'h0200, '0, 1, 13'h0001);
    pulse_reset(1'b1, 1'b1);
    cyc(1, 0, 15'h0200, '0, 0, '0);
    cyc(0, 0, '0, '0, 0, '0);
    chk("post_rst_data", 32'(bus.cpu_rdata), 32'(seed_word(15'h0200)));

    // Random traffic over small windows so reads hit earlier writes.
    for (int k = 0; k < 400; k++) begin
      creq  = ($urandom_range(0, 3) != 0);
      cwe   = $urandom_range(0, 1) == 1;
      caddr = ($urandom_range(0, 1) == 1) ? 15'($urandom_range(0, 63))
                                          : BASE + 15'($urandom_range(0, 63));
      sreq  = ($urandom_range(0, 2) != 0);
      saddr = 13'($urandom_range(0, 63));
      cyc(creq, cwe, caddr, 16'($urandom), sreq, saddr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
